// File: rtl/subtractor_sklansky_pipe.sv
// Two-stage pipelined unsigned subtractor, a - b - bin, on a Sklansky prefix carry network.
// The prefix levels are split across the two register stages with valid/ready backpressure.
module subtractor_sklansky_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             eq
);
    localparam int LVLS    = $clog2(WIDTH);
    localparam int S1_LVLS = (LVLS + 1) / 2;

    logic                      c0;
    logic [WIDTH-1:0]          p_raw, g_raw;
    logic [LVLS:0][WIDTH-1:0]  g_net, p_net;
    logic [LVLS-1:0][WIDTH-1:0] g_src, p_src;
    logic [WIDTH-1:0]          g_fin;

    logic                      s1_valid, s1_c0;
    logic [WIDTH-1:0]          s1_g, s1_p, s1_praw;
    logic                      s1_load, s2_load;

    logic [WIDTH-1:0]          diff_nxt;
    logic                      unused_p;

    assign c0    = ~bin;
    assign p_raw = a ^ ~b;
    assign g_raw = a & ~b;

    // Carry-in is folded into bit 0, so every prefix G is the true carry into the next bit.
    assign g_net[0] = {g_raw[WIDTH-1:1], g_raw[0] | (p_raw[0] & c0)};
    assign p_net[0] = {p_raw[WIDTH-1:1], 1'b0};

    genvar l, i;
    generate
        for (l = 0; l < LVLS; l++) begin : g_lvl
            // The level right after the stage cut reads the stage-1 registers.
            if (l == S1_LVLS) begin : g_cut
                assign g_src[l] = s1_g;
                assign p_src[l] = s1_p;
            end else begin : g_thru
                assign g_src[l] = g_net[l];
                assign p_src[l] = p_net[l];
            end
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (((i >> l) & 1) == 1) begin : g_comb
                    localparam int J = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
                    assign g_net[l+1][i] = g_src[l][i] | (p_src[l][i] & g_src[l][J]);
                    assign p_net[l+1][i] = p_src[l][i] & p_src[l][J];
                end else begin : g_pass
                    assign g_net[l+1][i] = g_src[l][i];
                    assign p_net[l+1][i] = p_src[l][i];
                end
            end
        end
        if (S1_LVLS == LVLS) begin : g_fin_reg
            assign g_fin = s1_g;
        end else begin : g_fin_net
            assign g_fin = g_net[LVLS];
        end
    endgenerate

    // Final-level group propagates carry no information once G is known.
    assign unused_p = ^{p_net[LVLS], s1_p};

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_praw  <= '0;
            s1_c0    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_g     <= g_net[S1_LVLS];
            s1_p     <= p_net[S1_LVLS];
            s1_praw  <= p_raw;
            s1_c0    <= c0;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    assign diff_nxt = s1_praw ^ {g_fin[WIDTH-2:0], s1_c0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            eq        <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            diff      <= diff_nxt;
            borrow    <= ~g_fin[WIDTH-1];
            eq        <= ~|diff_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/subtractor_sklansky_pipe.md
# subtractor_sklansky_pipe

Pipelined unsigned subtractor built on the same Sklansky parallel-prefix carry network as the team's prefix adders. It computes diff = a − b − bin, with borrow-out and a zero flag. It is the inverse-direction companion to the prefix adder family. It sits on a valid/ready stream between an operand producer and a result consumer, accepts one operation per cycle, and has two register stages with full backpressure.

## Interface
- WIDTH, 8, operand/result width; power of two, 2..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- borrow  output  1  1 when a < b + bin (unsigned)
- eq  output  1  1 when diff == 0

## Operation
- Arithmetic: a − b − bin = a + ~b + ~bin.
  - Per bit: p_i = a_i ^ ~b_i and g_i = a_i & ~b_i.
  - Carry-in c0 = ~bin is folded into bit 0: G0 = g_0 | (p_0 & c0).
- Prefix network: Sklansky with L = log2(WIDTH) levels.
  - At level l, each bit i with bit l of i set combines with the group ending at bit (i with bits l..0 cleared) + 2^l − 1.
  - Operator: (G,P) = (G_hi | (P_hi & G_lo), P_hi & P_lo).
- Sums and flags:
  - diff_0 = p_0 ^ c0.
  - diff_i = p_i ^ G[i−1:0] for i ≥ 1.
  - Carry-out co = G[WIDTH−1:0]; borrow = ~co.
  - eq is the NOR of diff.
- Stage 1 (S1) registers:
  - p/g after bit-0 folding and after prefix levels 0..ceil(L/2)−1.
  - Raw p vector.
  - s1_valid.
- Stage 2 (S2) registers:
  - Remaining prefix levels, then diff, borrow, eq.
  - out_valid.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready. Combinational; never depends on in_valid.
- Ordering: results emerge strictly in acceptance order, with no drop or duplication.
- Stalls: while out_valid && !out_ready, diff/borrow/eq are held stable. S1 holds once it is occupied.
- Bubbles: when S1 is empty and S2 drains, out_valid falls the cycle after the handshake.

## Timing
- Reset (async assert, synchronous-release use):
  - s1_valid = 0, out_valid = 0.
  - diff = 0, borrow = 0, eq = 0.
  - in_ready = 1.
- Latency:
  - An operand accepted at edge k appears with out_valid = 1 after edge k+1 when S2 is free.
  - It is visible in the cycle following edge k+1, i.e. 2 register stages and 1 cycle of occupancy in each.
- Throughput: 1 op/cycle with out_ready held high.
- Capacity: 2 results in flight. With out_ready low, the 3rd beat sees in_ready = 0.
- Simultaneous events:
  - An S2 drain plus S1→S2 transfer plus new accept can all occur in the same cycle.
  - in_ready stays 1 throughout.
- Reset mid-operation: all in-flight beats are discarded immediately. No result is produced after rst_n releases.
- Data registers: may omit reset only if out_valid gating is preserved. The required reset value of diff/borrow/eq is still 0.

## Test plan
- Basic subtraction, WIDTH=8, a=8'h05, b=8'h03, bin=0 -> diff=8'h02, borrow=0, eq=0, out_valid 2 cycles after accept.
- Borrow cases:
  - a=8'h03, b=8'h05, bin=0 -> diff=8'hFE, borrow=1.
  - a=8'h80, b=8'h80, bin=1 -> diff=8'hFF, borrow=1.
- Zero and all-ones:
  - a=8'h00, b=8'h00, bin=0 -> diff=8'h00, borrow=0, eq=1.
  - a=8'hFF, b=8'h00, bin=1 -> diff=8'hFE, borrow=0.
- Backpressure:
  - Setup: 4 back-to-back beats (10−1, 20−2, 30−3, 40−4), out_ready=0 for 4 cycles, then 1.
  - Required: in_ready drops after 2 accepts.
  - Required: outputs held stable during the stall, then 09, 12, 1B, 24 in order with no loss.
- Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle -> out_valid=0, diff=0, in_ready=1, and no stale result after release.
- Random streaming: 10k random a/b/bin with random in_valid/out_ready at WIDTH=8,16,64 -> every result matches the reference model, in order.
